// File: rtl/mux_select_sequencer_pkg.sv
// Shared types and widths for the mux select sequencer and its rate divider.
package mux_select_sequencer_pkg;

  localparam int unsigned MUX_SEL_W  = 3;
  localparam int unsigned MUX_DATA_W = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter width for a given period: $clog2(period), but never below 1 bit.
  function automatic int unsigned div_width(input int unsigned period);
    int unsigned w;
    w = $clog2(period);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_select_sequencer_rate_divider.sv
// Loadable down-counter with a zero flag; produces the bit-period tick for timed display paths.
module mux_select_sequencer_rate_divider
  import mux_select_sequencer_pkg::*;
#(
  parameter int unsigned Period = 4,
  parameter int unsigned Width  = div_width(Period)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [Width-1:0] Reload = Width'(Period - 1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = Reload;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mux_select_sequencer.sv
// Drives a 7-to-1 bit-select mux: holds a captured pattern and steps the select
// 0..NUM_BITS-1, one value per BIT_PERIOD clocks, with per-bit strobe and done pulse.
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 25000000,
  parameter int unsigned NUM_BITS   = 7
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [MUX_DATA_W-1:0] Pattern,
  output logic [MUX_SEL_W-1:0]  MuxSelect,
  output logic [MUX_DATA_W-1:0] MuxInput,
  output logic                  BitStrobe,
  output logic                  Busy,
  output logic                  Done
);

  localparam int unsigned          DivW    = div_width(BIT_PERIOD);
  localparam logic [MUX_SEL_W-1:0] LastSel = MUX_SEL_W'(NUM_BITS - 1);

  state_e                  state_q, state_d;
  logic [MUX_SEL_W-1:0]    sel_q, sel_d;
  logic [MUX_DATA_W-1:0]   data_q, data_d;
  logic                    strobe_q, strobe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    div_load;
  logic                    div_en;
  logic                    div_zero;

  mux_select_sequencer_rate_divider #(
    .Period (BIT_PERIOD),
    .Width  (DivW)
  ) u_rate_divider (
    .clk  (Clock),
    .rst  (Reset),
    .load (div_load),
    .en   (div_en),
    .zero (div_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        sel_d  = '0;
        busy_d = 1'b0;
        if (Start) begin
          state_d  = S_RUN;
          data_d   = Pattern;
          strobe_d = 1'b1;
          busy_d   = 1'b1;
          div_load = 1'b1;
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        if (!div_zero) begin
          div_en = 1'b1;
        end else if (sel_q < LastSel) begin
          sel_d    = sel_q + MUX_SEL_W'(1);
          strobe_d = 1'b1;
          div_load = 1'b1;
        end else begin
          // Select stays on the last bit through the single DONE cycle.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign MuxSelect = sel_q;
  assign MuxInput  = data_q;
  assign BitStrobe = strobe_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Self-checking bench: two instances (BIT_PERIOD=4 and BIT_PERIOD=1) against a cycle-offset model.
module tb_mux_select_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_start, a_strobe, a_busy, a_done;
  logic [6:0] a_pat, a_in;
  logic [2:0] a_sel;
  logic       b_rst, b_start, b_strobe, b_busy, b_done;
  logic [6:0] b_pat, b_in;
  logic [2:0] b_sel;

  int n_run  = 0;
  int n_fail = 0;

  logic exp_stream [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  mux_select_sequencer #(.BIT_PERIOD(4), .NUM_BITS(7)) dut_a (
    .Clock(clk), .Reset(a_rst), .Start(a_start), .Pattern(a_pat),
    .MuxSelect(a_sel), .MuxInput(a_in), .BitStrobe(a_strobe), .Busy(a_busy), .Done(a_done)
  );

  mux_select_sequencer #(.BIT_PERIOD(1), .NUM_BITS(7)) dut_b (
    .Clock(clk), .Reset(b_rst), .Start(b_start), .Pattern(b_pat),
    .MuxSelect(b_sel), .MuxInput(b_in), .BitStrobe(b_strobe), .Busy(b_busy), .Done(b_done)
  );

  logic [12:0] obs_a, obs_b;
  assign obs_a = {a_sel, a_in, a_strobe, a_busy, a_done};
  assign obs_b = {b_sel, b_in, b_strobe, b_busy, b_done};

  // Model: k counts cycles since the accepted Start (1 = first RUN cycle).
  typedef struct packed {
    logic        active;
    logic [31:0] k;
    logic [6:0]  held;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  function automatic mdl_t mdl_next(mdl_t m, logic rst, logic start, logic [6:0] pat,
                                    int unsigned p);
    mdl_t n;
    n = m;
    if (rst) begin
      n.active = 1'b0; n.k = 0; n.held = '0;
    end else if (!m.active) begin
      if (start) begin
        n.active = 1'b1; n.k = 1; n.held = pat;
      end
    end else if (m.k == 7 * p + 1) begin
      n.active = 1'b0; n.k = 0;
    end else begin
      n.k = m.k + 1;
    end
    return n;
  endfunction

  function automatic logic [12:0] mdl_exp(mdl_t m, int unsigned p);
    logic [2:0] sel;
    logic       st, bz, dn;
    sel = 3'd0; st = 1'b0; bz = 1'b0; dn = 1'b0;
    if (m.active) begin
      if (m.k <= 7 * p) begin
        sel = 3'((m.k - 1) / p);
        st  = ((m.k - 1) % p) == 0;
        bz  = 1'b1;
      end else begin
        sel = 3'd6;
        dn  = 1'b1;
      end
    end
    return {sel, m.held, st, bz, dn};
  endfunction

  always @(posedge clk) begin
    ma <= mdl_next(ma, a_rst, a_start, a_pat, 4);
    mb <= mdl_next(mb, b_rst, b_start, b_pat, 1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_both();
    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    tick();
    a_rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_both();
    n_run++;
    if (obs_a !== 13'd0) begin
      n_fail++; $display("FAIL reset_a got=%h exp=%h", obs_a, 13'd0);
    end
    n_run++;
    if (obs_b !== 13'd0) begin
      n_fail++; $display("FAIL reset_b got=%h exp=%h", obs_b, 13'd0);
    end
    n_run++;
    if (obs_a !== mdl_exp(ma, 4)) begin
      n_fail++; $display("FAIL reset_model_a got=%h exp=%h", obs_a, mdl_exp(ma, 4));
    end
  endtask

  task automatic test_basic();
    int busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    reset_both();
    a_pat = 7'b1010011; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n_run++;
    if (a_in !== 7'b1010011) begin
      n_fail++; $display("FAIL basic_capture got=%b exp=%b", a_in, 7'b1010011);
    end
    for (int c = 1; c <= 34; c++) begin
      n_run++;
      if (obs_a !== mdl_exp(ma, 4)) begin
        n_fail++; $display("FAIL basic_cycle c=%0d got=%h exp=%h", c, obs_a, mdl_exp(ma, 4));
      end
      if (a_busy) busy_cnt++;
      if (a_done) done_cnt++;
      if (c <= 28) begin
        n_run++;
        if (a_in[a_sel] !== exp_stream[(c - 1) / 4]) begin
          n_fail++;
          $display("FAIL basic_stream c=%0d got=%b exp=%b", c, a_in[a_sel], exp_stream[(c-1)/4]);
        end
      end
      a_pat = 7'($urandom);
      tick();
    end
    n_run++;
    if (busy_cnt != 28) begin
      n_fail++; $display("FAIL basic_busy_len got=%0d exp=28", busy_cnt);
    end
    n_run++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_ignored_start();
    logic [6:0] p;
    int done_at, done_cnt;
    done_at = 0; done_cnt = 0;
    reset_both();
    p = 7'($urandom);
    if (p == 7'h7F) p = 7'h15;
    a_pat = p; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      n_run++;
      if (obs_a !== mdl_exp(ma, 4)) begin
        n_fail++; $display("FAIL ignore_cycle c=%0d got=%h exp=%h", c, obs_a, mdl_exp(ma, 4));
      end
      if (a_done) begin done_at = c; done_cnt++; end
      a_start = (c == 10);
      a_pat   = (c == 10) ? 7'h7F : p;
      tick();
    end
    a_start = 1'b0;
    n_run++;
    if (done_at != 29 || done_cnt != 1) begin
      n_fail++; $display("FAIL ignore_done got=%0d/%0d exp=29/1", done_at, done_cnt);
    end
    n_run++;
    if (a_in !== p) begin
      n_fail++; $display("FAIL ignore_held got=%h exp=%h", a_in, p);
    end
  endtask

  task automatic test_min_period();
    int strobe_cnt, done_at;
    strobe_cnt = 0; done_at = 0;
    reset_both();
    b_pat = 7'($urandom); b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      n_run++;
      if (obs_b !== mdl_exp(mb, 1)) begin
        n_fail++; $display("FAIL minper_cycle c=%0d got=%h exp=%h", c, obs_b, mdl_exp(mb, 1));
      end
      if (b_strobe) strobe_cnt++;
      if (b_done) done_at = c;
      b_pat = 7'($urandom);
      tick();
    end
    n_run++;
    if (strobe_cnt != 7) begin
      n_fail++; $display("FAIL minper_strobes got=%0d exp=7", strobe_cnt);
    end
    n_run++;
    if (done_at != 8) begin
      n_fail++; $display("FAIL minper_done_cycle got=%0d exp=8", done_at);
    end
  endtask

  task automatic test_mid_reset();
    int done_cnt;
    done_cnt = 0;
    reset_both();
    a_pat = 7'($urandom) | 7'h01; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      n_run++;
      if (obs_a !== mdl_exp(ma, 4)) begin
        n_fail++; $display("FAIL midrst_cycle c=%0d got=%h exp=%h", c, obs_a, mdl_exp(ma, 4));
      end
      tick();
    end
    n_run++;
    if (a_sel !== 3'd3) begin
      n_fail++; $display("FAIL midrst_presel got=%0d exp=3", a_sel);
    end
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    n_run++;
    if (obs_a !== 13'd0) begin
      n_fail++; $display("FAIL midrst_after got=%h exp=%h", obs_a, 13'd0);
    end
    for (int c = 0; c < 40; c++) begin
      n_run++;
      if (obs_a !== mdl_exp(ma, 4)) begin
        n_fail++; $display("FAIL midrst_tail c=%0d got=%h exp=%h", c, obs_a, mdl_exp(ma, 4));
      end
      if (a_done) done_cnt++;
      tick();
    end
    n_run++;
    if (done_cnt != 0) begin
      n_fail++; $display("FAIL midrst_done got=%0d exp=0", done_cnt);
    end
  endtask

  task automatic test_reset_priority();
    logic [6:0] p;
    reset_both();
    a_rst = 1'b1; a_start = 1'b1; a_pat = 7'($urandom);
    tick();
    a_rst = 1'b0; a_start = 1'b0;
    n_run++;
    if (obs_a !== 13'd0) begin
      n_fail++; $display("FAIL prio_idle got=%h exp=%h", obs_a, 13'd0);
    end
    tick();
    n_run++;
    if (a_busy !== 1'b0) begin
      n_fail++; $display("FAIL prio_busy got=%b exp=0", a_busy);
    end
    p = 7'($urandom);
    a_pat = p; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n_run++;
    if (obs_a !== {3'd0, p, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL prio_start got=%h exp=%h", obs_a, {3'd0, p, 1'b1, 1'b1, 1'b0});
    end
    for (int c = 0; c < 32; c++) begin
      n_run++;
      if (obs_a !== mdl_exp(ma, 4)) begin
        n_fail++; $display("FAIL prio_seq c=%0d got=%h exp=%h", c, obs_a, mdl_exp(ma, 4));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int done_at, restarts;
    logic prev_busy;
    done_at = 0; restarts = 0; prev_busy = 1'b0;
    reset_both();
    a_start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      a_pat = 7'($urandom);
      tick();
      n_run++;
      if (obs_a !== mdl_exp(ma, 4)) begin
        n_fail++; $display("FAIL b2b_cycle c=%0d got=%h exp=%h", c, obs_a, mdl_exp(ma, 4));
      end
      n_run++;
      if (a_sel === 3'd7) begin
        n_fail++; $display("FAIL b2b_sel7 c=%0d got=%0d exp<7", c, a_sel);
      end
      if (a_busy && !prev_busy && done_at > 0) begin
        restarts++;
        n_run++;
        if (c != done_at + 2) begin
          n_fail++; $display("FAIL b2b_restart got=%0d exp=%0d", c, done_at + 2);
        end
      end
      if (a_done) done_at = c;
      prev_busy = a_busy;
    end
    a_start = 1'b0;
    n_run++;
    if (restarts < 2) begin
      n_fail++; $display("FAIL b2b_restarts got=%0d exp>=2", restarts);
    end
    repeat (35) tick();
  endtask

  task automatic test_random();
    reset_both();
    for (int c = 0; c < 600; c++) begin
      a_start = ($urandom % 6) == 0;
      a_rst   = ($urandom % 80) == 0;
      a_pat   = 7'($urandom);
      b_start = ($urandom % 4) == 0;
      b_rst   = ($urandom % 60) == 0;
      b_pat   = 7'($urandom);
      tick();
      n_run++;
      if (obs_a !== mdl_exp(ma, 4)) begin
        n_fail++; $display("FAIL rand_a c=%0d got=%h exp=%h", c, obs_a, mdl_exp(ma, 4));
      end
      n_run++;
      if (obs_b !== mdl_exp(mb, 1)) begin
        n_fail++; $display("FAIL rand_b c=%0d got=%h exp=%h", c, obs_b, mdl_exp(mb, 1));
      end
    end
    a_start = 1'b0; b_start = 1'b0; a_rst = 1'b0; b_rst = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_pat = '0;
    b_rst = 1'b1; b_start = 1'b0; b_pat = '0;
    test_reset();
    test_basic();
    test_ignored_start();
    test_min_period();
    test_mid_reset();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
